// File: rtl/klp32_result_checker.sv
// klp32_result_checker: compares NUM_CH observed channels against a preloaded per-step expected table.
// Optional KLP32_CHK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module klp32_result_checker #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_load_we,
    input  logic [AW-1:0]            i_load_addr,
    input  logic [CW-1:0]            i_load_ch,
    input  logic [DATA_W-1:0]        i_load_data,
    input  logic                     i_load_care,
    input  logic [AW:0]              i_num_vectors,
    input  logic                     i_start,
    input  logic                     i_step,
    input  logic [NUM_CH*DATA_W-1:0] i_actual,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_num_tests,
    output logic [CNT_W-1:0]         o_num_passes,
    output logic                     o_fail_seen,
    output logic [AW-1:0]            o_fail_idx,
    output logic [CW-1:0]            o_fail_ch,
    output logic [DATA_W-1:0]        o_fail_actual,
    output logic [DATA_W-1:0]        o_fail_expected
);
    localparam int AW1 = AW + 1;
    localparam int SW = CNT_W + $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] exp_q [DEPTH][NUM_CH];
    logic [DEPTH-1:0][NUM_CH-1:0] care_q;
    logic [AW-1:0] idx_q, idx_d, fidx_q, fidx_d;
    logic [AW:0] num_q, num_d, num_in;
    logic [CNT_W-1:0] tests_q, tests_d, passes_q, passes_d;
    logic fail_q, fail_d;
    logic [CW-1:0] fch_q, fch_d, mch;
    logic [DATA_W-1:0] fact_q, fact_d, fexp_q, fexp_d, mact, mexp;
    logic [SW-1:0] nc, np, tsum, psum;
    logic mis, step, load, kick, last, stop;
    assign step = state_q == RUN && i_step;
    assign load = i_load_we && state_q != RUN;
    assign kick = state_q != RUN && i_start;
    assign num_in = i_num_vectors > AW1'(DEPTH) ? AW1'(DEPTH) : i_num_vectors;
    assign last = {1'b0, idx_q} + AW1'(1) == num_q;
    assign tsum = SW'(tests_q) + nc;
    assign psum = SW'(passes_q) + np;
`ifdef KLP32_CHK_STOP_ON_FAIL_EN
    assign stop = mis && !fail_q;
`else
    assign stop = 1'b0;
`endif
    // Descending scan so the lowest mismatching care channel wins.
    always_comb begin
        nc = '0;
        np = '0;
        mis = 1'b0;
        mch = '0;
        mact = '0;
        mexp = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (care_q[idx_q][c]) begin
                nc = nc + SW'(1);
                if (i_actual[c*DATA_W +: DATA_W] == exp_q[idx_q][c]) np = np + SW'(1);
                else begin
                    mis = 1'b1;
                    mch = CW'(c);
                    mact = i_actual[c*DATA_W +: DATA_W];
                    mexp = exp_q[idx_q][c];
                end
            end
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (state_q == RUN) state_d = step && (last || stop) ? DONE : RUN;
        else if (i_start) state_d = num_in == '0 ? DONE : RUN;
    end
    always_comb begin
        o_busy = state_q == RUN;
        o_done = state_q == DONE;
    end
    // Passes freeze once tests has saturated so passes never overtakes tests.
    always_comb begin
        idx_d = idx_q;
        num_d = num_q;
        tests_d = tests_q;
        passes_d = passes_q;
        fail_d = fail_q;
        fidx_d = fidx_q;
        fch_d = fch_q;
        fact_d = fact_q;
        fexp_d = fexp_q;
        if (kick) begin
            idx_d = '0;
            num_d = num_in;
            tests_d = '0;
            passes_d = '0;
            fail_d = 1'b0;
            fidx_d = '0;
            fch_d = '0;
            fact_d = '0;
            fexp_d = '0;
        end else if (step) begin
            idx_d = idx_q + AW'(1);
            tests_d = tsum > SW'(CMAX) ? CMAX : tsum[CNT_W-1:0];
            passes_d = tests_q == CMAX ? passes_q : psum > SW'(CMAX) ? CMAX : psum[CNT_W-1:0];
            if (mis && !fail_q) begin
                fail_d = 1'b1;
                fidx_d = idx_q;
                fch_d = mch;
                fact_d = mact;
                fexp_d = mexp;
            end
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            care_q <= '0;
            idx_q <= '0;
            num_q <= '0;
            tests_q <= '0;
            passes_q <= '0;
            fail_q <= 1'b0;
            fidx_q <= '0;
            fch_q <= '0;
            fact_q <= '0;
            fexp_q <= '0;
        end else begin
            if (load) care_q[i_load_addr][i_load_ch] <= i_load_care;
            idx_q <= idx_d;
            num_q <= num_d;
            tests_q <= tests_d;
            passes_q <= passes_d;
            fail_q <= fail_d;
            fidx_q <= fidx_d;
            fch_q <= fch_d;
            fact_q <= fact_d;
            fexp_q <= fexp_d;
        end
    always_ff @(posedge clk)
        if (load) exp_q[i_load_addr][i_load_ch] <= i_load_data;
    assign o_num_tests = tests_q;
    assign o_num_passes = passes_q;
    assign o_fail_seen = fail_q;
    assign o_fail_idx = fidx_q;
    assign o_fail_ch = fch_q;
    assign o_fail_actual = fact_q;
    assign o_fail_expected = fexp_q;
endmodule

// File: doc/klp32_result_checker.md
Name: klp32_result_checker

Overview:
- Synthesizable, parametrised self-checking block for KLP32 bring-up. It compares up to NUM_CH processor observation channels (writeback, ALU out, regData2, memRW, ...) against a preloaded per-step expected-vector table, one vector per retired instruction.
- It keeps test/pass counters and captures the first mismatch, so directed instruction checks can run on FPGA or in simulation without a behavioural testbench.
- It sits beside the KLP32 core and taps the core's debug output ports.

Parameters:
- NUM_CH, 4, number of observed channels compared per step.
- DATA_W, 32, width of each channel; narrower signals are zero-extended by the integrator.
- DEPTH, 64, number of expected vectors held; must be a power of two, at least 2.
- CNT_W, 16, width of the test and pass counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_load_we  in  1  write one expected entry this cycle.
- i_load_addr  in  $clog2(DEPTH)  vector index to write.
- i_load_ch  in  $clog2(NUM_CH) (min 1)  channel to write.
- i_load_data  in  DATA_W  expected value.
- i_load_care  in  1  1 = channel compared at this index, 0 = don't-care.
- i_num_vectors  in  $clog2(DEPTH)+1  vectors to check in this run; sampled on start.
- i_start  in  1  begin a run.
- i_step  in  1  one instruction retired; compare this cycle.
- i_actual  in  NUM_CH*DATA_W  packed observed values, channel 0 in LSBs.
- o_busy  out  1  in RUN state.
- o_done  out  1  in DONE state.
- o_num_tests  out  CNT_W  number of channel comparisons performed.
- o_num_passes  out  CNT_W  number of matching comparisons.
- o_fail_seen  out  1  sticky, at least one mismatch this run.
- o_fail_idx  out  $clog2(DEPTH)  vector index of the first mismatch.
- o_fail_ch  out  $clog2(NUM_CH) (min 1)  lowest mismatching channel at that index.
- o_fail_actual  out  DATA_W  observed value at the first mismatch.
- o_fail_expected  out  DATA_W  expected value at the first mismatch.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; the index register is cleared.
  - All outputs go to 0.
  - Table contents are undefined after reset, except that every care bit clears to 0.
- States:
  - IDLE. On i_start: clear the counters, o_fail_* and the index; latch i_num_vectors. If the latched count is 0, go to DONE; otherwise go to RUN.
  - RUN. o_busy=1. Each cycle with i_step=1, compare all channels of vector[index] against i_actual in the same cycle.
  - DONE. o_done=1 and all results are held. i_start restarts exactly as from IDLE.
- Update rule for a step in RUN (all registered on that rising edge, visible after it):
  - o_num_tests += number of care channels.
  - o_num_passes += number of care channels with actual == expected.
  - Then index += 1.
  - If index+1 == latched count, go to DONE on the same edge.
- First fail capture:
  - When o_fail_seen=0 and any care channel mismatches, set o_fail_seen and capture the index.
  - Capture the lowest mismatching channel, with its actual and expected values.
  - Later mismatches never overwrite the capture.
- Counters saturate at 2^CNT_W-1; no wrap-around. When o_num_tests saturates, o_num_passes also stops incrementing.
- A latched count greater than DEPTH is clamped to DEPTH.
- A vector with no care channels still consumes a step; the counters are unchanged.
- i_start while in RUN is ignored.
- i_step while in IDLE or DONE is ignored.
- i_load_we while in RUN is ignored, so the table cannot be corrupted mid-run. In IDLE or DONE it writes the value and care bit in one cycle.
- i_load_we and i_start in the same cycle (IDLE): the write lands and the run starts; index 0 sees the new data only if its address is not compared before the next edge, which always holds because the first compare is at the next step.
- i_step and the final step: o_done asserts the cycle after the last counted step.
- Reset during RUN aborts the run immediately; all outputs return to 0.

Optional Feature:
- Macro KLP32_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in RUN moves to DONE on that same edge. The counters include that step; later steps are ignored.
- Undefined: the run always continues to the latched count regardless of mismatches.

Test Plan:
1. Load 4 vectors on ch0 (5, 4, 1, 0) with care=1 and other channels care=0; start with num=4; 4 steps matching -> tests=4, passes=4, fail_seen=0, done=1 after 4th step.
2. Same table, step 3 drives ch0=7 -> tests=4, passes=3, fail_idx=2, fail_ch=0, actual=7, expected=1. With STOP_ON_FAIL_EN: done after step 3 and tests=3.
3. Vector 0 has all 4 channels care, and ch1 and ch3 mismatch -> tests=4, passes=2, fail_ch=1.
4. Start with num=0 -> done next cycle, counters 0. Start with num=DEPTH+5 -> exactly DEPTH steps accepted.
5. Assert reset mid-run after 2 of 4 steps -> all outputs 0, IDLE. A load attempted during RUN leaves the table unchanged (verify on rerun).
6. Force counters near saturation (CNT_W=3, 3 vectors with 4 care channels each, all pass) -> tests=7, passes=7.
